// File: rtl/audio_pkg.sv
// Shared audio-path types: pan state encoding, unity gain helper, codec word width.
// Pure declarations; no latency or flow control of its own.
package audio_pkg;

  typedef enum logic [1:0] {
    HOLD_L,
    HOLD_R,
    RAMP_TO_R,
    RAMP_TO_L
  } pan_state_t;

  localparam int CODEC_W = 24;

  function automatic int gain_full(input int gw);
    return 1 << gw;
  endfunction

endpackage

// File: rtl/dff.sv
// Plain resettable register, used as a synchroniser stage.
// One cycle latency; no flow control.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/sample_scaler.sv
// Signed sample times unsigned Q.GW gain, arithmetic shift back to 16 bits.
// One cycle latency, result captured only when en is high; no backpressure.
module sample_scaler #(
  parameter int GW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic signed [15:0] sample,
  input  logic        [GW:0] gain,
  output logic signed [15:0] scaled
);

  localparam int PW = 17 + GW;

  logic signed [PW-1:0] prod;

  // Gain is zero-extended so the multiply stays signed; gain <= unity keeps the result in 16 bits.
  assign prod = $signed({{(PW-16){sample[15]}}, sample}) *
                $signed({{(PW-GW-1){1'b0}}, gain});

  always_ff @(posedge clk) begin
    if (reset)   scaled <= '0;
    else if (en) scaled <= 16'(prod >>> GW);
  end

endmodule

// File: rtl/stereo_pan_ramp.sv
// Routes the mono sample to left or right headphone, crossfading over codec frames on a switch change.
// Output updates two cycles after new_frame; no backpressure, one frame accepted per cycle.
module stereo_pan_ramp
  import audio_pkg::*;
#(
  parameter int GW   = 8,
  parameter int STEP = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stereo_sel,
  input  logic        [15:0] sample_in,
  input  logic               sample_valid,
  input  logic               new_frame,
  output logic [CODEC_W-1:0] hphone_l,
  output logic [CODEC_W-1:0] hphone_r,
  output logic               ramp_active
);

  localparam logic [GW:0] FULL   = (GW+1)'(gain_full(GW));
  localparam logic [GW:0] STEP_G = (GW+1)'(STEP);

  logic               sel_m, sel_s;
  logic signed [15:0] hold;
  logic        [GW:0] gain_l, gain_r;
  logic        [GW:0] gl_up, gl_dn, gr_up, gr_dn;
  logic               to_r_done, to_l_done;
  logic               frame_d;
  logic signed [15:0] scaled_l, scaled_r;
  pan_state_t         state;

  function automatic logic [GW:0] step_up(input logic [GW:0] g);
    logic [GW+1:0] s;
    s = {1'b0, g} + {1'b0, STEP_G};
    return (s >= {1'b0, FULL}) ? FULL : s[GW:0];
  endfunction

  function automatic logic [GW:0] step_dn(input logic [GW:0] g);
    return (g <= STEP_G) ? '0 : g - STEP_G;
  endfunction

  dff #(.W(1)) u_sync_0 (.clk(clk), .reset(reset), .d(stereo_sel), .q(sel_m));
  dff #(.W(1)) u_sync_1 (.clk(clk), .reset(reset), .d(sel_m),      .q(sel_s));

  always_ff @(posedge clk) begin
    if (reset)             hold <= '0;
    else if (sample_valid) hold <= sample_in;
  end

  always_comb begin
    gl_up     = step_up(gain_l);
    gl_dn     = step_dn(gain_l);
    gr_up     = step_up(gain_r);
    gr_dn     = step_dn(gain_r);
    to_r_done = (gr_up == FULL) && (gl_dn == '0);
    to_l_done = (gl_up == FULL) && (gr_dn == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HOLD_L;
      gain_l      <= FULL;
      gain_r      <= '0;
      ramp_active <= 1'b0;
    end else begin
      case (state)
        HOLD_L: if (sel_s) begin
          state       <= RAMP_TO_R;
          ramp_active <= 1'b1;
        end
        HOLD_R: if (!sel_s) begin
          state       <= RAMP_TO_L;
          ramp_active <= 1'b1;
        end
        default: begin
          // Direction tracks the live switch, so a reversal resumes from the current gains.
          if (!new_frame) begin
            state <= sel_s ? RAMP_TO_R : RAMP_TO_L;
          end else if (sel_s) begin
            gain_r      <= gr_up;
            gain_l      <= gl_dn;
            state       <= to_r_done ? HOLD_R : RAMP_TO_R;
            ramp_active <= !to_r_done;
          end else begin
            gain_l      <= gl_up;
            gain_r      <= gr_dn;
            state       <= to_l_done ? HOLD_L : RAMP_TO_L;
            ramp_active <= !to_l_done;
          end
        end
      endcase
    end
  end

  sample_scaler #(.GW(GW)) u_scale_l (
    .clk(clk), .reset(reset), .en(new_frame), .sample(hold), .gain(gain_l), .scaled(scaled_l)
  );
  sample_scaler #(.GW(GW)) u_scale_r (
    .clk(clk), .reset(reset), .en(new_frame), .sample(hold), .gain(gain_r), .scaled(scaled_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_d  <= 1'b0;
      hphone_l <= '0;
      hphone_r <= '0;
    end else begin
      frame_d <= new_frame;
      if (frame_d) begin
        hphone_l <= {scaled_l, {(CODEC_W-16){1'b0}}};
        hphone_r <= {scaled_r, {(CODEC_W-16){1'b0}}};
      end
    end
  end

endmodule
